// File: rtl/seg_pkg.sv
// Segment codes, converter state type and sizing helpers shared by the
// 74HC595 seven-segment scan path.
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // one segment byte followed by the digit select field
  function automatic int frame_w(input int dig_num);
    return 8 + dig_num;
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_595_scan_bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, DATA_W cycles per
// conversion, result held on bcd after done until the next start.
module bcd_seq
  import seg_pkg::*;
#(
  parameter int DATA_W  = 20,
  parameter int DIG_NUM = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_W-1:0]      data,
  output logic                   done,
  output logic [DIG_NUM*4-1:0]   bcd
);
  localparam int CW = $clog2(DATA_W + 1);

  bcd_state_t           state, state_nx;
  logic [DATA_W-1:0]    bin;
  logic [CW-1:0]        cnt;
  logic [DIG_NUM*4-1:0] adj;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == CW'(DATA_W - 1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign done = (state == DONE);

  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIG_NUM; i++)
      if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
  end

  // digits above DIG_NUM are dropped; the top level flags that as overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bin   <= '0;
      cnt   <= '0;
      bcd   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        bin <= data;
        bcd <= '0;
        cnt <= '0;
      end else if (state == SHIFT) begin
        bcd <= {adj[DIG_NUM*4-2:0], bin[DATA_W-1]};
        bin <= bin << 1;
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/seg_595_scan.sv
// Binary value to multiplexed seven-segment display through chained 74HC595s.
// Define SEG_DIM_EN to add the bright[3:0] input and PWM dimming on oe.
module seg_595_scan
  import seg_pkg::*;
#(
  parameter int DIG_NUM  = 6,
  parameter int DATA_W   = 20,
  parameter int SCAN_CNT = 50000,
  parameter int SHCP_DIV = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [DATA_W-1:0]  data,
  input  logic [DIG_NUM-1:0] point,
  input  logic               sign,
  input  logic               seg_en,
`ifdef SEG_DIM_EN
  input  logic [3:0]         bright,
`endif
  output logic               stcp,
  output logic               shcp,
  output logic               ds,
  output logic               oe
);
  localparam int FW  = frame_w(DIG_NUM);
  localparam int SCW = $clog2(SCAN_CNT);
  localparam int IW  = (DIG_NUM > 1) ? $clog2(DIG_NUM) : 1;
  localparam int DW  = (SHCP_DIV > 1) ? $clog2(SHCP_DIV) : 1;
  localparam int HW  = $clog2(2 * FW + 1);
  localparam logic [63:0] OVF_TH = pow10(DIG_NUM);

  logic [SCW-1:0] scan_cnt;
  logic [IW-1:0]  dig_idx;
  logic           slot_start, frame_end;

  assign slot_start = (scan_cnt == '0);
  assign frame_end  = (scan_cnt == SCW'(SCAN_CNT - 1)) && (dig_idx == IW'(DIG_NUM - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else if (scan_cnt == SCW'(SCAN_CNT - 1)) begin
      scan_cnt <= '0;
      dig_idx  <= (dig_idx == IW'(DIG_NUM - 1)) ? '0 : dig_idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + SCW'(1);
    end
  end

  logic                 cv_done;
  logic [DIG_NUM*4-1:0] cv_bcd;

  bcd_seq #(.DATA_W(DATA_W), .DIG_NUM(DIG_NUM)) u_bcd (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .start (frame_end),
    .data  (data),
    .done  (cv_done),
    .bcd   (cv_bcd)
  );

  // Display state is swapped on the last cycle of a frame so every slot of
  // the following frame renders the same value.
  logic                 res_new, cap_ovf, disp_vld, disp_ovf, disp_sign;
  logic [DIG_NUM*4-1:0] disp_bcd;
  logic [DIG_NUM-1:0]   disp_pt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      res_new   <= 1'b0;
      cap_ovf   <= 1'b0;
      disp_vld  <= 1'b0;
      disp_ovf  <= 1'b0;
      disp_sign <= 1'b0;
      disp_bcd  <= '1;
      disp_pt   <= '0;
    end else begin
      if (frame_end) cap_ovf <= (64'(data) >= OVF_TH);
      if (cv_done) res_new <= 1'b1;
      else if (frame_end && res_new) begin
        res_new   <= 1'b0;
        disp_vld  <= 1'b1;
        disp_ovf  <= cap_ovf;
        disp_bcd  <= cv_bcd;
        disp_pt   <= point;
        disp_sign <= sign;
      end
    end
  end

  logic [7:0]         seg;
  logic [DIG_NUM-1:0] sel;
  logic [3:0]         nib;
  int                 msd, idx;

  always_comb begin
    msd = 0;
    idx = int'(dig_idx);
    nib = disp_bcd[3:0];
    for (int i = 1; i < DIG_NUM; i++) begin
      if (disp_bcd[i*4 +: 4] != 4'd0) msd = i;
      if (idx == i) nib = disp_bcd[i*4 +: 4];
    end
    if (!disp_vld)     seg = SEG_BLANK;
    else if (disp_ovf) seg = SEG_MINUS;
    else begin
      if (idx <= msd)                        seg = seg_code(nib);
      else if (disp_sign && idx == msd + 1)  seg = SEG_MINUS;
      else                                   seg = SEG_BLANK;
      if (disp_pt[dig_idx]) seg[7] = 1'b0;
    end
    if (!seg_en) seg = SEG_BLANK;
    sel = seg_en ? (DIG_NUM'(1) << dig_idx) : '0;
  end

  // half counts shcp half-periods: even = low, odd = high; after the last
  // bit one extra half-period carries the stcp pulse.
  logic [FW-1:0] sr;
  logic          sh_act, armed;
  logic [DW-1:0] div;
  logic [HW-1:0] half;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sr <= '0; sh_act <= 1'b0; div <= '0; half <= '0; armed <= 1'b0;
      stcp <= 1'b0; shcp <= 1'b0; ds <= 1'b0;
    end else if (slot_start) begin
      sr <= {seg, sel}; ds <= seg[7]; sh_act <= 1'b1;
      div <= '0; half <= '0; shcp <= 1'b0; stcp <= 1'b0;
    end else if (sh_act) begin
      if (div == DW'(SHCP_DIV - 1)) begin
        div  <= '0;
        half <= half + HW'(1);
        if (half == HW'(2 * FW)) begin
          stcp <= 1'b0; sh_act <= 1'b0; armed <= 1'b1;
        end else if (!half[0]) begin
          shcp <= 1'b1;
        end else begin
          shcp <= 1'b0;
          if (half == HW'(2 * FW - 1)) stcp <= 1'b1;
          else begin
            sr <= sr << 1;
            ds <= sr[FW-2];
          end
        end
      end else begin
        div <= div + DW'(1);
      end
    end
  end

  logic oe_on;
`ifdef SEG_DIM_EN
  logic [3:0] pre, pwm;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pre <= '0;
      pwm <= '0;
    end else begin
      pre <= pre + 4'd1;
      if (pre == 4'hF) pwm <= pwm + 4'd1;
    end
  end
  assign oe_on = armed && seg_en && (pwm < bright);
`else
  assign oe_on = armed && seg_en;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) oe <= 1'b1;
    else         oe <= !oe_on;
  end

endmodule
